// File: rtl/arith_exec_port_pkg.sv
// Shared definitions for the dual-lane arithmetic execution port:
// opcode values, function-type encodings and flag bit positions.
package arith_exec_port_pkg;

  localparam logic [6:0] OP_NOP = 7'h00;
  localparam logic [6:0] OP_ADD = 7'h01;
  localparam logic [6:0] OP_SUB = 7'h02;
  localparam logic [6:0] OP_AND = 7'h03;
  localparam logic [6:0] OP_OR  = 7'h04;
  localparam logic [6:0] OP_XOR = 7'h05;
  localparam logic [6:0] OP_SHL = 7'h06;
  localparam logic [6:0] OP_SHR = 7'h07;
  localparam logic [6:0] OP_MOV = 7'h08;
  localparam logic [6:0] OP_MUL = 7'h09;
  localparam logic [6:0] OP_CMP = 7'h0A;

  typedef enum logic [1:0] {
    FT_ARITH  = 2'b00,
    FT_LDST   = 2'b01,
    FT_BRANCH = 2'b10,
    FT_RSVD   = 2'b11
  } ftype_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_is_legal(input logic [6:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/arith_lane.sv
// One execution lane: E1 operand capture (with MUL partial products),
// E2 ALU, flag update, writeback strobe and retired counter.
module arith_lane
  import arith_exec_port_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              wb_i,
  input  logic [6:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] prim_i,
  input  logic [DATA_W-1:0] sec_i,
  input  logic [1:0]        ftype_i,
  input  logic              suppress_i,
  output logic              wb_next_o,
  output logic [ADDR_W-1:0] addr_next_o,
  output logic              wb_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_val_o,
  output logic [3:0]        flags_o,
  output logic              illegal_o,
  output logic [15:0]       retired_o
);

  localparam int HALF = DATA_W / 2;
  localparam int MSB  = DATA_W - 1;

  logic              e1_valid_d, e1_valid_q;
  logic              e1_wb_d, e1_wb_q;
  logic [6:0]        e1_op_d, e1_op_q;
  logic [ADDR_W-1:0] e1_addr_d, e1_addr_q;
  logic [DATA_W-1:0] e1_prim_d, e1_prim_q;
  logic [DATA_W-1:0] e1_sec_d, e1_sec_q;
  logic [DATA_W-1:0] e1_pp_lo_d, e1_pp_lo_q;
  logic [DATA_W-1:0] e1_pp_hi_d, e1_pp_hi_q;
  logic [DATA_W-1:0] sec_lo_s, sec_hi_s;

  logic [DATA_W:0]   sum_s, diff_s, shl_s, shr_s;
  logic [DATA_W-1:0] res_s;
  logic              carry_s, ovf_s, legal_s, exec_s;
  logic [3:0]        flags_new_s;

  logic              wb_d, wb_q;
  logic [ADDR_W-1:0] wb_addr_d, wb_addr_q;
  logic [DATA_W-1:0] wb_val_d, wb_val_q;
  logic [3:0]        flags_d, flags_q;
  logic              illegal_d, illegal_q;
  logic [15:0]       retired_d, retired_q;

  // E1 capture; the multiplier is split into two half-width partial products here
  always_comb begin
    e1_valid_d = enable_i & (ftype_i == FT_ARITH);
    e1_wb_d    = wb_i;
    e1_op_d    = op_i;
    e1_addr_d  = addr_i;
    e1_prim_d  = prim_i;
    e1_sec_d   = sec_i;
    sec_lo_s   = {{(DATA_W-HALF){1'b0}}, sec_i[HALF-1:0]};
    sec_hi_s   = {{HALF{1'b0}}, sec_i[DATA_W-1:HALF]};
    e1_pp_lo_d = prim_i * sec_lo_s;
    e1_pp_hi_d = prim_i * sec_hi_s;
  end

  // E2 ALU evaluated in DATA_W+1 bits so carry/borrow fall out of the top bit
  always_comb begin
    sum_s   = {1'b0, e1_prim_q} + {1'b0, e1_sec_q};
    diff_s  = {1'b0, e1_prim_q} - {1'b0, e1_sec_q};
    shl_s   = {1'b0, e1_prim_q} << e1_sec_q[3:0];
    shr_s   = {e1_prim_q, 1'b0} >> e1_sec_q[3:0];
    res_s   = {DATA_W{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (e1_op_q)
      OP_ADD: begin
        res_s   = sum_s[DATA_W-1:0];
        carry_s = sum_s[DATA_W];
        ovf_s   = (e1_prim_q[MSB] == e1_sec_q[MSB]) & (sum_s[MSB] != e1_prim_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res_s   = diff_s[DATA_W-1:0];
        carry_s = diff_s[DATA_W];
        ovf_s   = (e1_prim_q[MSB] != e1_sec_q[MSB]) & (diff_s[MSB] != e1_prim_q[MSB]);
      end
      OP_AND: res_s = e1_prim_q & e1_sec_q;
      OP_OR:  res_s = e1_prim_q | e1_sec_q;
      OP_XOR: res_s = e1_prim_q ^ e1_sec_q;
      OP_SHL: begin
        res_s   = shl_s[DATA_W-1:0];
        carry_s = shl_s[DATA_W];
      end
      OP_SHR: begin
        res_s   = shr_s[DATA_W:1];
        carry_s = shr_s[0];
      end
      OP_MOV: res_s = e1_sec_q;
      OP_MUL: res_s = e1_pp_lo_q + (e1_pp_hi_q << HALF);
      default: res_s = {DATA_W{1'b0}};
    endcase
    flags_new_s         = 4'b0000;
    flags_new_s[FLAG_Z] = (res_s == {DATA_W{1'b0}});
    flags_new_s[FLAG_N] = res_s[MSB];
    flags_new_s[FLAG_C] = carry_s;
    flags_new_s[FLAG_V] = ovf_s;
  end

  // E2 qualification: strobe, illegal pulse, flag and counter updates
  always_comb begin
    legal_s     = op_is_legal(e1_op_q);
    exec_s      = e1_valid_q & legal_s & (e1_op_q != OP_NOP);
    wb_next_o   = exec_s & e1_wb_q & (e1_op_q != OP_CMP);
    addr_next_o = e1_addr_q;
    wb_d        = wb_next_o & ~suppress_i;
    illegal_d   = e1_valid_q & ~legal_s;
    if (exec_s) begin
      flags_d   = flags_new_s;
      retired_d = retired_q + 16'd1;
    end else begin
      flags_d   = flags_q;
      retired_d = retired_q;
    end
    if (wb_d) begin
      wb_addr_d = e1_addr_q;
      wb_val_d  = res_s;
    end else begin
      wb_addr_d = wb_addr_q;
      wb_val_d  = wb_val_q;
    end
  end

  // Pipeline and architectural state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e1_valid_q <= 1'b0;
      e1_wb_q    <= 1'b0;
      e1_op_q    <= 7'h00;
      e1_addr_q  <= {ADDR_W{1'b0}};
      e1_prim_q  <= {DATA_W{1'b0}};
      e1_sec_q   <= {DATA_W{1'b0}};
      e1_pp_lo_q <= {DATA_W{1'b0}};
      e1_pp_hi_q <= {DATA_W{1'b0}};
      wb_q       <= 1'b0;
      wb_addr_q  <= {ADDR_W{1'b0}};
      wb_val_q   <= {DATA_W{1'b0}};
      flags_q    <= 4'b0000;
      illegal_q  <= 1'b0;
      retired_q  <= 16'h0000;
    end else begin
      e1_valid_q <= e1_valid_d;
      e1_wb_q    <= e1_wb_d;
      e1_op_q    <= e1_op_d;
      e1_addr_q  <= e1_addr_d;
      e1_prim_q  <= e1_prim_d;
      e1_sec_q   <= e1_sec_d;
      e1_pp_lo_q <= e1_pp_lo_d;
      e1_pp_hi_q <= e1_pp_hi_d;
      wb_q       <= wb_d;
      wb_addr_q  <= wb_addr_d;
      wb_val_q   <= wb_val_d;
      flags_q    <= flags_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign wb_o      = wb_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_val_o  = wb_val_q;
  assign flags_o   = flags_q;
  assign illegal_o = illegal_q;
  assign retired_o = retired_q;

endmodule

// File: rtl/arith_exec_port.sv
// Dual-lane arithmetic execution port. Lane B is the younger instruction, so a
// same-address writeback collision drops lane A's strobe before it is registered.
module arith_exec_port
  import arith_exec_port_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enableA_i,
  input  logic              enableB_i,
  input  logic              wbA_i,
  input  logic              wbB_i,
  input  logic [6:0]        opCodeA_i,
  input  logic [6:0]        opCodeB_i,
  input  logic [ADDR_W-1:0] regAddrA_i,
  input  logic [ADDR_W-1:0] regAddrB_i,
  input  logic [DATA_W-1:0] primOperandA_i,
  input  logic [DATA_W-1:0] primOperandB_i,
  input  logic [DATA_W-1:0] secOperandA_i,
  input  logic [DATA_W-1:0] secOperandB_i,
  input  logic [1:0]        functionTypeA_i,
  input  logic [1:0]        functionTypeB_i,
  output logic              wbA_arith_o,
  output logic              wbB_arith_o,
  output logic [ADDR_W-1:0] wbAddrA_arith_o,
  output logic [ADDR_W-1:0] wbAddrB_arith_o,
  output logic [DATA_W-1:0] wbValA_arith_o,
  output logic [DATA_W-1:0] wbValB_arith_o,
  output logic [3:0]        flagsA_o,
  output logic [3:0]        flagsB_o,
  output logic              illegalA_o,
  output logic              illegalB_o,
  output logic [15:0]       retiredA_o,
  output logic [15:0]       retiredB_o
);

  logic              wb_next_a_s, wb_next_b_s, suppress_a_s;
  logic [ADDR_W-1:0] addr_next_a_s, addr_next_b_s;

  // Collision check uses the E2 next-state strobes so the output stays registered
  always_comb begin
    suppress_a_s = wb_next_a_s & wb_next_b_s & (addr_next_a_s == addr_next_b_s);
  end

  arith_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane_a (
    .clk_i      (clock_i),
    .rst_ni     (reset_i),
    .enable_i   (enableA_i),
    .wb_i       (wbA_i),
    .op_i       (opCodeA_i),
    .addr_i     (regAddrA_i),
    .prim_i     (primOperandA_i),
    .sec_i      (secOperandA_i),
    .ftype_i    (functionTypeA_i),
    .suppress_i (suppress_a_s),
    .wb_next_o  (wb_next_a_s),
    .addr_next_o(addr_next_a_s),
    .wb_o       (wbA_arith_o),
    .wb_addr_o  (wbAddrA_arith_o),
    .wb_val_o   (wbValA_arith_o),
    .flags_o    (flagsA_o),
    .illegal_o  (illegalA_o),
    .retired_o  (retiredA_o)
  );

  arith_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane_b (
    .clk_i      (clock_i),
    .rst_ni     (reset_i),
    .enable_i   (enableB_i),
    .wb_i       (wbB_i),
    .op_i       (opCodeB_i),
    .addr_i     (regAddrB_i),
    .prim_i     (primOperandB_i),
    .sec_i      (secOperandB_i),
    .ftype_i    (functionTypeB_i),
    .suppress_i (1'b0),
    .wb_next_o  (wb_next_b_s),
    .addr_next_o(addr_next_b_s),
    .wb_o       (wbB_arith_o),
    .wb_addr_o  (wbAddrB_arith_o),
    .wb_val_o   (wbValB_arith_o),
    .flags_o    (flagsB_o),
    .illegal_o  (illegalB_o),
    .retired_o  (retiredB_o)
  );

endmodule

// File: tb/tb_arith_exec_port.sv
// Self-checking bench for arith_exec_port: directed cases plus random traffic,
// compared against an integer-arithmetic reference model with a 2-cycle delay queue.
module tb_arith_exec_port;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enableA_i, enableB_i, wbA_i, wbB_i;
  logic [6:0]  opCodeA_i, opCodeB_i;
  logic [4:0]  regAddrA_i, regAddrB_i;
  logic [15:0] primOperandA_i, primOperandB_i, secOperandA_i, secOperandB_i;
  logic [1:0]  functionTypeA_i, functionTypeB_i;
  logic        wbA_arith_o, wbB_arith_o;
  logic [4:0]  wbAddrA_arith_o, wbAddrB_arith_o;
  logic [15:0] wbValA_arith_o, wbValB_arith_o;
  logic [3:0]  flagsA_o, flagsB_o;
  logic        illegalA_o, illegalB_o;
  logic [15:0] retiredA_o, retiredB_o;

  arith_exec_port #(.DATA_W(16), .ADDR_W(5)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .enableA_i(enableA_i), .enableB_i(enableB_i),
    .wbA_i(wbA_i), .wbB_i(wbB_i),
    .opCodeA_i(opCodeA_i), .opCodeB_i(opCodeB_i),
    .regAddrA_i(regAddrA_i), .regAddrB_i(regAddrB_i),
    .primOperandA_i(primOperandA_i), .primOperandB_i(primOperandB_i),
    .secOperandA_i(secOperandA_i), .secOperandB_i(secOperandB_i),
    .functionTypeA_i(functionTypeA_i), .functionTypeB_i(functionTypeB_i),
    .wbA_arith_o(wbA_arith_o), .wbB_arith_o(wbB_arith_o),
    .wbAddrA_arith_o(wbAddrA_arith_o), .wbAddrB_arith_o(wbAddrB_arith_o),
    .wbValA_arith_o(wbValA_arith_o), .wbValB_arith_o(wbValB_arith_o),
    .flagsA_o(flagsA_o), .flagsB_o(flagsB_o),
    .illegalA_o(illegalA_o), .illegalB_o(illegalB_o),
    .retiredA_o(retiredA_o), .retiredB_o(retiredB_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic        wb;
    logic [4:0]  addr;
    logic [15:0] val;
    logic [3:0]  flags;
    logic        ill;
    logic [15:0] ret;
  } lane_exp_t;

  typedef struct packed {
    lane_exp_t a;
    lane_exp_t b;
  } exp_t;

  exp_t        expq[$];
  logic [3:0]  m_flags[2];
  logic [15:0] m_ret[2];
  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [15:0] wrap_start_a, wrap_start_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: plain integer arithmetic on unsigned and signed views
  function automatic void alu_model(input int op, input int a, input int b,
                                    output int res, output logic [3:0] fl);
    longint full;
    int sa, sb, sv, n;
    logic c, v;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    n  = b % 16;
    c  = 1'b0;
    v  = 1'b0;
    res = 0;
    case (op)
      1: begin
        full = longint'(a) + longint'(b);
        res  = int'(full % 64'sd65536);
        c    = (full > 64'sd65535);
        sv   = sa + sb;
        v    = (sv > 32767) || (sv < -32768);
      end
      2, 10: begin
        res = (a - b + 65536) % 65536;
        c   = (a < b);
        sv  = sa - sb;
        v   = (sv > 32767) || (sv < -32768);
      end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: begin
        res = (a << n) % 65536;
        c   = (n > 0) && (((a >> (16 - n)) & 1) == 1);
      end
      7: begin
        res = a >> n;
        c   = (n > 0) && (((a >> (n - 1)) & 1) == 1);
      end
      8: res = b;
      9: begin
        full = longint'(a) * longint'(b);
        res  = int'(full % 64'sd65536);
      end
      default: res = 0;
    endcase
    fl = {(res == 0), (res >= 32768), c, v};
  endfunction

  function automatic lane_exp_t model_lane(input int l, input logic en, input logic wb,
                                           input logic [6:0] op, input logic [4:0] ad,
                                           input logic [15:0] p, input logic [15:0] s,
                                           input logic [1:0] ft);
    lane_exp_t e;
    int res;
    logic [3:0] fl;
    e = '0;
    if (en && ft == 2'b00) begin
      if (op > 7'h0A) begin
        e.ill = 1'b1;
      end else if (op != 7'h00) begin
        alu_model(int'(op), int'(p), int'(s), res, fl);
        m_flags[l] = fl;
        m_ret[l]   = m_ret[l] + 16'd1;
        if (wb && op != 7'h0A) begin
          e.wb   = 1'b1;
          e.addr = ad;
          e.val  = res[15:0];
        end
      end
    end
    e.flags = m_flags[l];
    e.ret   = m_ret[l];
    return e;
  endfunction

  function automatic exp_t idle_entry();
    exp_t e;
    e = '0;
    e.a.flags = m_flags[0];
    e.a.ret   = m_ret[0];
    e.b.flags = m_flags[1];
    e.b.ret   = m_ret[1];
    return e;
  endfunction

  task automatic restart_model();
    m_flags[0] = 4'h0; m_flags[1] = 4'h0;
    m_ret[0]   = 16'h0; m_ret[1]  = 16'h0;
    expq.delete();
    expq.push_back(idle_entry());
  endtask

  task automatic push_issue();
    exp_t e;
    e.a = model_lane(0, enableA_i, wbA_i, opCodeA_i, regAddrA_i, primOperandA_i, secOperandA_i, functionTypeA_i);
    e.b = model_lane(1, enableB_i, wbB_i, opCodeB_i, regAddrB_i, primOperandB_i, secOperandB_i, functionTypeB_i);
    if (e.a.wb && e.b.wb && e.a.addr == e.b.addr) e.a.wb = 1'b0;
    expq.push_back(e);
  endtask

  task automatic chk_lane(input string ln, input lane_exp_t e, input logic wb, input logic [4:0] ad,
                          input logic [15:0] v, input logic [3:0] fl, input logic ill,
                          input logic [15:0] ret);
    chk({ln, "_wb"}, 32'(wb), 32'(e.wb));
    if (e.wb) begin
      chk({ln, "_addr"}, 32'(ad), 32'(e.addr));
      chk({ln, "_val"}, 32'(v), 32'(e.val));
    end
    chk({ln, "_flags"}, 32'(fl), 32'(e.flags));
    chk({ln, "_illegal"}, 32'(ill), 32'(e.ill));
    chk({ln, "_retired"}, 32'(ret), 32'(e.ret));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock_i);
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk_lane("laneA", e.a, wbA_arith_o, wbAddrA_arith_o, wbValA_arith_o, flagsA_o, illegalA_o, retiredA_o);
      chk_lane("laneB", e.b, wbB_arith_o, wbAddrB_arith_o, wbValB_arith_o, flagsB_o, illegalB_o, retiredB_o);
    end
  endtask

  task automatic step();
    push_issue();
    tick();
  endtask

  task automatic setA(input logic en, input logic wb, input logic [6:0] op, input logic [4:0] ad,
                      input logic [15:0] p, input logic [15:0] s, input logic [1:0] ft);
    enableA_i = en; wbA_i = wb; opCodeA_i = op; regAddrA_i = ad;
    primOperandA_i = p; secOperandA_i = s; functionTypeA_i = ft;
  endtask

  task automatic setB(input logic en, input logic wb, input logic [6:0] op, input logic [4:0] ad,
                      input logic [15:0] p, input logic [15:0] s, input logic [1:0] ft);
    enableB_i = en; wbB_i = wb; opCodeB_i = op; regAddrB_i = ad;
    primOperandB_i = p; secOperandB_i = s; functionTypeB_i = ft;
  endtask

  task automatic set_idle();
    setA(1'b0, 1'b0, 7'h00, 5'd0, 16'h0000, 16'h0000, 2'b00);
    setB(1'b0, 1'b0, 7'h00, 5'd0, 16'h0000, 16'h0000, 2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wbA"}, 32'(wbA_arith_o), 32'd0);
    chk({tag, "_wbB"}, 32'(wbB_arith_o), 32'd0);
    chk({tag, "_addrA"}, 32'(wbAddrA_arith_o), 32'd0);
    chk({tag, "_addrB"}, 32'(wbAddrB_arith_o), 32'd0);
    chk({tag, "_valA"}, 32'(wbValA_arith_o), 32'd0);
    chk({tag, "_valB"}, 32'(wbValB_arith_o), 32'd0);
    chk({tag, "_flagsA"}, 32'(flagsA_o), 32'd0);
    chk({tag, "_flagsB"}, 32'(flagsB_o), 32'd0);
    chk({tag, "_illA"}, 32'(illegalA_o), 32'd0);
    chk({tag, "_illB"}, 32'(illegalB_o), 32'd0);
    chk({tag, "_retA"}, 32'(retiredA_o), 32'd0);
    chk({tag, "_retB"}, 32'(retiredB_o), 32'd0);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_lane(output logic en, output logic wb, output logic [6:0] op,
                           output logic [4:0] ad, output logic [15:0] p, output logic [15:0] s,
                           output logic [1:0] ft);
    int r;
    en = ($urandom_range(0, 7) != 0);
    wb = ($urandom_range(0, 3) != 0);
    r  = $urandom_range(0, 12);
    op = (r == 12) ? 7'($urandom_range(11, 127)) : 7'(r);
    ad = 5'($urandom_range(0, 3));
    p  = pick_operand();
    s  = pick_operand();
    ft = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
  endtask

  initial begin
    reset_i = 1'b0;
    set_idle();
    #22;
    check_all_zero("reset");
    reset_i = 1'b1;
    restart_model();

    // ADD overflow into sign bit
    setA(1'b1, 1'b1, 7'h01, 5'd3, 16'h7FFF, 16'h0001, 2'b00);
    step();
    set_idle();
    step();
    chk("add_wbA", 32'(wbA_arith_o), 32'd1);
    chk("add_addrA", 32'(wbAddrA_arith_o), 32'd3);
    chk("add_valA", 32'(wbValA_arith_o), 32'h8000);
    chk("add_flagsA", 32'(flagsA_o), 32'b0101);

    // SUB with borrow then CMP equal, back-to-back on lane B
    setB(1'b1, 1'b1, 7'h02, 5'd9, 16'h0000, 16'h0001, 2'b00);
    step();
    setB(1'b1, 1'b1, 7'h0A, 5'd10, 16'h0005, 16'h0005, 2'b00);
    step();
    chk("sub_wbB", 32'(wbB_arith_o), 32'd1);
    chk("sub_valB", 32'(wbValB_arith_o), 32'hFFFF);
    chk("sub_flagsB", 32'(flagsB_o), 32'b0110);
    set_idle();
    step();
    chk("cmp_wbB", 32'(wbB_arith_o), 32'd0);
    chk("cmp_flagsB", 32'(flagsB_o), 32'b1000);

    // MUL on A, SHL with carry-out on B
    setA(1'b1, 1'b1, 7'h09, 5'd4, 16'h0100, 16'h0101, 2'b00);
    setB(1'b1, 1'b1, 7'h06, 5'd5, 16'h8001, 16'h0001, 2'b00);
    step();
    set_idle();
    step();
    chk("mul_valA", 32'(wbValA_arith_o), 32'h0100);
    chk("shl_valB", 32'(wbValB_arith_o), 32'h0002);
    chk("shl_carryB", 32'(flagsB_o[1]), 32'd1);

    // Illegal opcode: pulse only, no state change
    setA(1'b1, 1'b1, 7'h7F, 5'd6, 16'h1234, 16'h5678, 2'b00);
    step();
    set_idle();
    step();
    chk("ill_pulseA", 32'(illegalA_o), 32'd1);
    chk("ill_wbA", 32'(wbA_arith_o), 32'd0);
    chk("ill_flagsA", 32'(flagsA_o), 32'b0000);
    chk("ill_retA", 32'(retiredA_o), 32'd2);
    step();
    chk("ill_pulse_endA", 32'(illegalA_o), 32'd0);

    // Same-address collision: younger lane B wins
    setA(1'b1, 1'b1, 7'h01, 5'd7, 16'h0001, 16'h0002, 2'b00);
    setB(1'b1, 1'b1, 7'h01, 5'd7, 16'h0003, 16'h0004, 2'b00);
    step();
    set_idle();
    step();
    chk("coll_wbA", 32'(wbA_arith_o), 32'd0);
    chk("coll_wbB", 32'(wbB_arith_o), 32'd1);
    chk("coll_addrB", 32'(wbAddrB_arith_o), 32'd7);
    chk("coll_valB", 32'(wbValB_arith_o), 32'd7);

    // Load/store function type is ignored
    setA(1'b1, 1'b1, 7'h01, 5'd8, 16'h0001, 16'h0001, 2'b01);
    setB(1'b1, 1'b1, 7'h01, 5'd8, 16'h0001, 16'h0001, 2'b01);
    step();
    set_idle();
    step();
    chk("ldst_wbA", 32'(wbA_arith_o), 32'd0);
    chk("ldst_wbB", 32'(wbB_arith_o), 32'd0);
    chk("ldst_retA", 32'(retiredA_o), 32'd3);
    chk("ldst_retB", 32'(retiredB_o), 32'd4);

    // Reset asserted with instructions in E1 and at the issue port
    setA(1'b1, 1'b1, 7'h01, 5'd1, 16'h0011, 16'h0022, 2'b00);
    setB(1'b1, 1'b1, 7'h05, 5'd2, 16'h00F0, 16'h0F0F, 2'b00);
    step();
    setA(1'b1, 1'b1, 7'h08, 5'd2, 16'h0000, 16'hBEEF, 2'b00);
    push_issue();
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clock_i);
    @(posedge clock_i);
    #1;
    check_all_zero("midreset_hold");
    set_idle();
    @(negedge clock_i);
    reset_i = 1'b1;
    restart_model();
    for (int i = 0; i < 3; i++) step();
    chk("post_reset_wbA", 32'(wbA_arith_o), 32'd0);
    chk("post_reset_wbB", 32'(wbB_arith_o), 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rand_lane(enableA_i, wbA_i, opCodeA_i, regAddrA_i, primOperandA_i, secOperandA_i, functionTypeA_i);
      rand_lane(enableB_i, wbB_i, opCodeB_i, regAddrB_i, primOperandB_i, secOperandB_i, functionTypeB_i);
      step();
    end

    // Retired counters wrap after 65536 more ops
    wrap_start_a = m_ret[0];
    wrap_start_b = m_ret[1];
    setA(1'b1, 1'b0, 7'h0A, 5'd0, 16'h0003, 16'h0001, 2'b00);
    setB(1'b1, 1'b0, 7'h0A, 5'd0, 16'h0001, 16'h0003, 2'b00);
    for (int i = 0; i < 65536; i++) step();
    set_idle();
    step();
    step();
    chk("wrap_retA", 32'(retiredA_o), 32'(wrap_start_a));
    chk("wrap_retB", 32'(retiredB_o), 32'(wrap_start_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
